mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants allowed while a fetch request waits.
REQ-002 SHALL have parameter AW, default 32, meaning the address width.
REQ-003 SHALL have port clk, input, 1, the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-low.
REQ-005 SHALL have i_req/i_addr, input, 1/AW, the fetch-stage read request and its address.
REQ-006 SHALL have i_gnt/i_rvalid/i_rdata, output, 1/1/32, the fetch grant pulse, response pulse and read data.
REQ-007 SHALL have d_req/d_we/d_addr/d_wdata, input, 1/1/AW/32, the memory-stage request, its write enable, address and write data.
REQ-008 SHALL have d_gnt/d_rvalid/d_rdata, output, 1/1/32, the data grant pulse, completion pulse and read data.
REQ-009 SHALL have mem_req/mem_we/mem_addr/mem_wdata, output, 1/1/AW/32, driving the single shared memory port.
REQ-010 SHALL have mem_gnt/mem_rvalid/mem_rdata, input, 1/1/32, the memory acceptance, response and read data; every access, reads and writes alike, gets exactly one mem_rvalid.
REQ-011 SHALL have err, output, 1, a sticky flag for a protocol violation.

Function
REQ-012 SHALL implement the FSM states IDLE, ISSUE and WAIT, with one outstanding memory transaction at most.
REQ-013 In IDLE with any request, SHALL select an owner, register the owner and payload, pulse the owner's gnt for 1 cycle, and enter ISSUE on the next edge.
REQ-014 Priority SHALL be data over fetch, except that fetch wins when i_req=1 and starve_cnt==STARVE_LIMIT.
REQ-015 starve_cnt SHALL increment on each data grant while i_req=1, clear on a fetch grant or when i_req=0, and saturate at STARVE_LIMIT.
REQ-016 In ISSUE, SHALL assert mem_req=1 with the registered payload and hold it stable until mem_gnt=1, then move to WAIT.
REQ-017 If mem_gnt and mem_rvalid are both 1 in ISSUE, SHALL complete directly, routing the response and returning to IDLE.
REQ-018 In WAIT, on mem_rvalid=1, SHALL pulse the owner's rvalid for 1 cycle with rdata=mem_rdata registered, then return to IDLE.
REQ-019 Response latency SHALL be grant-to-rvalid of at least 2 cycles plus the memory latency; a new grant is never issued in the same cycle as a response.
REQ-020 A requester SHALL hold req/address/data stable until its gnt pulse; any req change before gnt is the requester's fault and is not checked.
REQ-021 mem_rvalid seen in IDLE, or in ISSUE without mem_gnt, SHALL set err=1 and be otherwise ignored.
REQ-022 i_rdata/d_rdata SHALL hold the last delivered value between pulses; the non-owner's rvalid stays 0.
REQ-023 mem_we SHALL be 0 for any fetch-owned access.

Reset
REQ-024 When rst=0 at a clock edge, SHALL set the FSM to IDLE, starve_cnt=0, err=0, and all gnt, rvalid, mem_req and mem_we outputs to 0, with the addr, wdata and rdata outputs at 0.
REQ-025 A reset mid-transaction SHALL abandon the transaction, with any later mem_rvalid in IDLE flagging err as in REQ-021.

Structure
REQ-026 Shared package riscv_mem_pkg SHALL hold the state encoding, the owner enum (OWN_I, OWN_D) and the default STARVE_LIMIT.
REQ-027 The priority select and starvation counter SHALL be one sub-module, mem_arb_prio; all else is flat.

Verification
REQ-028 Bench SHALL cover: i_req only, addr 0x100, memory with 1-cycle latency -> i_gnt in cycle 0, mem_req in cycle 1, i_rvalid with the data in cycle 3; d_gnt never asserts.
REQ-029 Bench SHALL cover: i_req and d_req both held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-030 Bench SHALL cover: d_we=1, addr 0x20, wdata 0xDEADBEEF, mem_gnt delayed 3 cycles -> mem_* held stable for 3 cycles, then one d_rvalid.
REQ-031 Bench SHALL cover: mem_gnt and mem_rvalid in the same ISSUE cycle -> owner rvalid on the next cycle, FSM back in IDLE.
REQ-032 Bench SHALL cover: rst=0 during WAIT, then mem_rvalid after release -> no rvalid to either requester, err=1.
REQ-033 Bench SHALL cover: rst=0 for 1 cycle with requests pending -> all outputs 0 on the next edge, and arbitration resumes after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared FSM encoding, owner enum and default starvation limit
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
  localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-over-fetch priority select with fetch starvation counter
module mem_arb_prio
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  output logic gnt_i,
  output logic gnt_d
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  // Fetch overrides data once it has watched STARVE_LIMIT data grants go by
  always_comb begin
    gnt_i = en && i_req && (!d_req || starve_cnt_q == LIMIT);
    gnt_d = en && d_req && !gnt_i;
    starve_cnt_d = (!i_req || gnt_i) ? '0
                 : (gnt_d && starve_cnt_q != LIMIT) ? starve_cnt_q + 1'b1 : starve_cnt_q;
  end
  // Starvation counter register
  always_ff @(posedge clk)
    starve_cnt_q <= rst ? starve_cnt_d : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          err
);
  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          err_q, err_d;
  logic          gnt_i, gnt_d, done;
  // No grant while a response pulse is out, so grant and response never coincide
  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk   (clk),
    .rst   (rst),
    .en    (rst && state_q == IDLE && !i_rvalid_q && !d_rvalid_q),
    .i_req (i_req),
    .d_req (d_req),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );
  assign i_gnt     = gnt_i;
  assign d_gnt     = gnt_d;
  assign mem_req   = state_q == ISSUE;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  // Transaction FSM: capture on grant, hold payload until accepted, route the single response
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = err_q || mem_rvalid;
        if (gnt_i || gnt_d) begin
          state_d = ISSUE;
          owner_d = gnt_i ? OWN_I : OWN_D;
          addr_d  = gnt_i ? i_addr : d_addr;
          we_d    = gnt_d && d_we;
          wdata_d = gnt_i ? '0 : d_wdata;
        end
      end
      ISSUE: begin
        err_d   = err_q || (mem_rvalid && !mem_gnt);
        state_d = !mem_gnt ? ISSUE : mem_rvalid ? IDLE : WAIT;
        done    = mem_gnt && mem_rvalid;
      end
      WAIT: begin
        state_d = mem_rvalid ? IDLE : WAIT;
        done    = mem_rvalid;
      end
      default: state_d = IDLE;
    endcase
    i_rvalid_d = done && owner_q == OWN_I;
    d_rvalid_d = done && owner_q == OWN_D;
    i_rdata_d  = i_rvalid_d ? mem_rdata : i_rdata_q;
    d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
  end
  // State registers, cleared by the synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          total = 0;
  int          bad = 0;
  bit          busy, acc, resp_due, own_d, t_we, g_i, g_d;
  logic [31:0] t_addr, t_wdata, resp_data, exp_i_rdata, exp_d_rdata;
  int          starve;
  string       order;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string t);
    check1({t, "_i_gnt"}, i_gnt, 1'b0);
    check1({t, "_d_gnt"}, d_gnt, 1'b0);
    check1({t, "_i_rvalid"}, i_rvalid, 1'b0);
    check1({t, "_d_rvalid"}, d_rvalid, 1'b0);
    check1({t, "_mem_req"}, mem_req, 1'b0);
    check1({t, "_mem_we"}, mem_we, 1'b0);
    check1({t, "_err"}, err, 1'b0);
    check32({t, "_mem_addr"}, mem_addr, 32'h0);
    check32({t, "_mem_wdata"}, mem_wdata, 32'h0);
    check32({t, "_i_rdata"}, i_rdata, 32'h0);
    check32({t, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  task automatic clear_mem;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
  endtask

  // One cycle of model-driven traffic: a transaction occupies the port from its grant
  // through its response pulse; fetch wins only when alone or after LIMIT data grants
  task automatic rand_cycle(input bit keep, input bit det);
    bit ig, dg, issuing;
    tick;
    if (g_i) begin i_req = keep; i_addr = $urandom; end
    if (g_d) begin
      d_req = keep; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
    end
    g_i = 1'b0;
    g_d = 1'b0;
    if (!keep && !i_req && $urandom_range(0, 1) == 1) begin i_req = 1'b1; i_addr = $urandom; end
    if (!keep && !d_req && $urandom_range(0, 1) == 1) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
    end
    if (keep) begin i_req = 1'b1; d_req = 1'b1; end
    issuing = busy && !acc;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    if (issuing) begin
      mem_gnt = det || $urandom_range(0, 1) == 1;
      mem_rvalid = !det && mem_gnt && $urandom_range(0, 2) == 0;
    end else if (busy && !resp_due)
      mem_rvalid = det || $urandom_range(0, 2) == 0;
    #1;
    if (resp_due && !own_d) exp_i_rdata = resp_data;
    if (resp_due && own_d) exp_d_rdata = resp_data;
    ig = !busy && i_req && (!d_req || starve == LIMIT);
    dg = !busy && d_req && !ig;
    check1("r_i_gnt", i_gnt, ig);
    check1("r_d_gnt", d_gnt, dg);
    check1("r_mem_req", mem_req, issuing);
    if (issuing) begin
      check32("r_mem_addr", mem_addr, t_addr);
      check1("r_mem_we", mem_we, t_we);
      if (t_we) check32("r_mem_wdata", mem_wdata, t_wdata);
    end
    check1("r_i_rvalid", i_rvalid, resp_due && !own_d);
    check1("r_d_rvalid", d_rvalid, resp_due && own_d);
    check32("r_i_rdata", i_rdata, exp_i_rdata);
    check32("r_d_rdata", d_rdata, exp_d_rdata);
    check1("r_err", err, 1'b0);
    if (resp_due) begin busy = 1'b0; resp_due = 1'b0; end
    else if (busy && mem_rvalid) begin resp_due = 1'b1; resp_data = mem_rdata; end
    if (issuing && mem_gnt) acc = 1'b1;
    if (!i_req || ig) starve = 0;
    else if (dg && starve < LIMIT) starve++;
    if (ig || dg) begin
      busy = 1'b1; acc = 1'b0; own_d = dg;
      t_addr = ig ? i_addr : d_addr;
      t_we = dg && d_we;
      t_wdata = d_wdata;
      order = {order, ig ? "I" : "D"};
      g_i = ig;
      g_d = dg;
    end
  endtask

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    clear_mem;
    tick;
    tick;
    check_zero("reset");
    rst = 1'b1;
    tick;

    // fetch only, 1-cycle memory latency
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    check1("f_i_gnt", i_gnt, 1'b1);
    check1("f_d_gnt0", d_gnt, 1'b0);
    check1("f_mem_req0", mem_req, 1'b0);
    tick;
    i_req = 1'b0; i_addr = 32'h0; mem_gnt = 1'b1;
    #1;
    check1("f_mem_req1", mem_req, 1'b1);
    check32("f_mem_addr", mem_addr, 32'h100);
    check1("f_mem_we", mem_we, 1'b0);
    check1("f_d_gnt1", d_gnt, 1'b0);
    tick;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check1("f_mem_req2", mem_req, 1'b0);
    check1("f_i_rvalid2", i_rvalid, 1'b0);
    tick;
    clear_mem;
    #1;
    check1("f_i_rvalid3", i_rvalid, 1'b1);
    check32("f_i_rdata3", i_rdata, 32'h1234_5678);
    check1("f_d_rvalid3", d_rvalid, 1'b0);
    check1("f_d_gnt3", d_gnt, 1'b0);
    tick;
    check1("f_i_rvalid4", i_rvalid, 1'b0);
    check32("f_i_rdata_hold", i_rdata, 32'h1234_5678);

    // data write with mem_gnt delayed 3 cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    #1;
    check1("w_d_gnt", d_gnt, 1'b1);
    check1("w_i_gnt", i_gnt, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      mem_gnt = k == 3;
      #1;
      check1("w_mem_req", mem_req, 1'b1);
      check1("w_mem_we", mem_we, 1'b1);
      check32("w_mem_addr", mem_addr, 32'h20);
      check32("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    tick;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h30;
    #1;
    check1("w_d_rvalid_early", d_rvalid, 1'b0);
    tick;
    clear_mem;
    #1;
    check1("w_d_rvalid", d_rvalid, 1'b1);
    check1("w_i_rvalid", i_rvalid, 1'b0);
    check32("w_d_rdata", d_rdata, 32'h30);
    tick;
    check1("w_d_rvalid_once", d_rvalid, 1'b0);
    check1("w_err", err, 1'b0);

    // mem_gnt and mem_rvalid together in ISSUE
    i_req = 1'b1; i_addr = 32'h44;
    #1;
    check1("s_i_gnt", i_gnt, 1'b1);
    tick;
    i_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0031;
    #1;
    check1("s_mem_req", mem_req, 1'b1);
    check32("s_mem_addr", mem_addr, 32'h44);
    tick;
    clear_mem;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    #1;
    check1("s_i_rvalid", i_rvalid, 1'b1);
    check32("s_i_rdata", i_rdata, 32'hA5A5_0031);
    check1("s_mem_req_idle", mem_req, 1'b0);
    check1("s_no_gnt_with_resp", d_gnt, 1'b0);
    check1("s_err", err, 1'b0);
    tick;
    check1("s_d_gnt_after", d_gnt, 1'b1);
    tick;
    d_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h31;
    tick;
    clear_mem;
    #1;
    check1("s_d_rvalid", d_rvalid, 1'b1);
    check32("s_d_rdata", d_rdata, 32'h31);

    // reset during WAIT, then a stray response
    tick;
    i_req = 1'b1; i_addr = 32'h80;
    #1;
    check1("x_i_gnt", i_gnt, 1'b1);
    tick;
    i_req = 1'b0; mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0; rst = 1'b0;
    tick;
    check_zero("x_reset");
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0BAD;
    tick;
    clear_mem;
    #1;
    check1("x_i_rvalid", i_rvalid, 1'b0);
    check1("x_d_rvalid", d_rvalid, 1'b0);
    check1("x_err", err, 1'b1);
    check32("x_i_rdata", i_rdata, 32'h0);

    // one-cycle reset with both requests pending, then arbitration resumes
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h55;
    rst = 1'b0;
    #1;
    check1("q_i_gnt_rst", i_gnt, 1'b0);
    check1("q_d_gnt_rst", d_gnt, 1'b0);
    tick;
    check_zero("q_reset");
    rst = 1'b1;
    #1;
    check1("q_d_gnt", d_gnt, 1'b1);
    check1("q_i_gnt", i_gnt, 1'b0);
    tick;
    d_req = 1'b0; mem_gnt = 1'b1;
    #1;
    check32("q_mem_addr_d", mem_addr, 32'h300);
    check1("q_mem_we_d", mem_we, 1'b1);
    check32("q_mem_wdata", mem_wdata, 32'h55);
    tick;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    tick;
    clear_mem;
    #1;
    check1("q_d_rvalid", d_rvalid, 1'b1);
    check1("q_i_gnt_resp", i_gnt, 1'b0);
    tick;
    check1("q_i_gnt2", i_gnt, 1'b1);
    tick;
    i_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h88;
    #1;
    check32("q_mem_addr_i", mem_addr, 32'h200);
    check1("q_mem_we_i", mem_we, 1'b0);
    tick;
    clear_mem;
    #1;
    check1("q_i_rvalid", i_rvalid, 1'b1);
    check32("q_i_rdata", i_rdata, 32'h88);

    // resynchronise the model with a reset, then saturating traffic and random traffic
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    busy = 1'b0; acc = 1'b0; resp_due = 1'b0; own_d = 1'b0; t_we = 1'b0;
    g_i = 1'b0; g_d = 1'b0; starve = 0; order = "";
    t_addr = 32'h0; t_wdata = 32'h0; resp_data = 32'h0;
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
    for (int k = 0; k < 40; k++) rand_cycle(1'b1, 1'b1);
    total++;
    assert (order.substr(0, 9) == "DDDDIDDDDI") else begin
      bad++;
      $error("FAIL grant_order: observed=%s expected=DDDDIDDDDI", order);
    end
    for (int k = 0; k < 400; k++) rand_cycle(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
